// File: rtl/pack_writeback_pkg.sv
// pack_writeback_pkg: shared state encoding, word geometry and lane-to-mask lookup
package pack_writeback_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} wb_state_e;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [3:0] MASK_L0 = 4'h1;
    localparam logic [3:0] MASK_L1 = 4'h3;
    localparam logic [3:0] MASK_L2 = 4'h7;
    localparam logic [3:0] MASK_L3 = 4'hF;
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return lane == 2'd0 ? MASK_L0 : lane == 2'd1 ? MASK_L1 : lane == 2'd2 ? MASK_L2 : MASK_L3;
    endfunction
endpackage

// File: rtl/pack_writeback.sv
// pack_writeback: counts packer lanes and writes each completed or final partial word to SRAM
// Ports: clk/rst (async active-high), start/base_addr/num_bytes begin a layer,
// byte_valid/pack_data mirror the packer, pack_clear restarts packer alignment,
// sram_we/sram_addr/sram_wdata/sram_wmask drive the SRAM, busy/done/err_overrun report status.
module pack_writeback
    import pack_writeback_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_bytes,
    input  logic              byte_valid,
    input  logic [31:0]       pack_data,
    output logic              pack_clear,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_wmask,
    output logic              busy,
    output logic              done,
    output logic              err_overrun
);
    wb_state_e                             state;
    logic [$clog2(BYTES_PER_WORD)-1:0]     lane;
    logic [CNT_W-1:0]                      bytes_seen;
    logic [CNT_W-1:0]                      num_q;
    logic [ADDR_W-1:0]                     word_ptr;
    logic                                  wr_pend;
    logic [3:0]                            mask_q;
    logic                                  last;
    assign last = (bytes_seen + CNT_W'(1)) == num_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lane        <= '0;
            bytes_seen  <= '0;
            num_q       <= '0;
            word_ptr    <= '0;
            wr_pend     <= 1'b0;
            mask_q      <= '0;
            err_overrun <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend) word_ptr <= word_ptr + ADDR_W'(1);
            case (state)
                IDLE: if (start) begin
                    word_ptr    <= base_addr;
                    num_q       <= num_bytes;
                    err_overrun <= 1'b0;
                    lane        <= '0;
                    bytes_seen  <= '0;
                    state       <= num_bytes == '0 ? DONE : RUN;
                end
                RUN: if (byte_valid) begin
                    lane       <= lane + 2'd1;
                    bytes_seen <= bytes_seen + CNT_W'(1);
                    // the packer holds the word during the next cycle, so the write lags by one
                    if (lane == 2'd3 || last) begin
                        wr_pend <= 1'b1;
                        mask_q  <= lane_mask(lane);
                    end
                    if (last) state <= FLUSH;
                end
                FLUSH: state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
            if (byte_valid && state != RUN) err_overrun <= 1'b1;
        end
    end
    assign sram_we    = wr_pend;
    assign sram_addr  = word_ptr;
    assign sram_wdata = pack_data;
    assign sram_wmask = wr_pend ? mask_q : 4'h0;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign pack_clear = state == IDLE || state == DONE;
endmodule
